vga_sync_monitor: RTL and testbench

- Receive-side counterpart of the vga timing generator: samples hsync, vsync and 12-bit RGB on the pixel clock.
- Recovers the pixel coordinates, checks line and frame timing, and locks onto the stream.
- Produces a per-frame additive checksum of active pixels.
- Used in simulation benches and as an on-chip self-check of the layer compositing output.

---
 rtl/vga_sync_monitor.sv | 169 ++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates from hsync/vsync,
// locks after two clean frames, flags bad line/frame lengths and checksums each frame.
module vga_sync_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_done,
    output logic [23:0] frame_sum,
    output logic        err_hlen,
    output logic        err_vlen
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
    localparam logic [10:0] H_FIRST   = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_LAST    = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0]  V_FIRST   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_LAST    = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [10:0] HPOS_MAX  = 11'h7FF;

    typedef enum logic [1:0] {SEEK, CHECK, LOCKED} state_t;

    function automatic logic [10:0] hpos_sat_inc(input logic [10:0] v);
        return (v == HPOS_MAX) ? v : v + 11'd1;
    endfunction

    state_t      state, state_nxt;
    logic        hs_p0, hs_p1, vs_p0, vs_p1;
    logic [11:0] rgb_p0;
    logic [10:0] hpos, hpos_nxt;
    logic [9:0]  vpos, vpos_nxt;
    logic        vpend;
    logic [1:0]  good_frames, good_nxt;
    logic [23:0] acc, acc_sum;
    logic        hfall, vfall, active_nxt;
    logic        line_bad, frame_bad, hmiss;
    logic        set_hlen, set_vlen, report;

    assign hfall = hs_p1 & ~hs_p0;
    assign vfall = vs_p1 & ~vs_p0;

    // hpos/vpos registers name the sample that has just left rgb_p0, so the
    // *_nxt values describe the sample currently sitting in rgb_p0.
    assign hpos_nxt = hfall ? 11'd0 : hpos_sat_inc(hpos);
    assign vpos_nxt = hfall ? ((vfall | vpend) ? 10'd0 : vpos + 10'd1) : vpos;

    assign active_nxt = (hpos_nxt >= H_FIRST) && (hpos_nxt <= H_LAST) &&
                        (vpos_nxt >= V_FIRST) && (vpos_nxt <= V_LAST);

    assign line_bad  = hfall && (({1'b0, hpos} + 12'd1) != H_TOTAL_C);
    assign frame_bad = vfall && (({1'b0, vpos} + 11'd1) != V_TOTAL_C);
    assign hmiss     = (hpos == HPOS_MAX) && !hfall;

    assign acc_sum = acc + (active_nxt ? {12'd0, rgb_p0} : 24'd0);

    assign locked = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        good_nxt  = good_frames;
        set_hlen  = 1'b0;
        set_vlen  = 1'b0;
        report    = 1'b0;
        case (state)
            SEEK: begin
                if (vfall) begin
                    state_nxt = CHECK;
                    good_nxt  = 2'd0;
                end
            end
            CHECK: begin
                if (line_bad || frame_bad) begin
                    set_hlen  = line_bad;
                    set_vlen  = frame_bad;
                    state_nxt = SEEK;
                end else if (vfall) begin
                    good_nxt = good_frames + 2'd1;
                    if (good_frames == 2'd1) state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (line_bad || frame_bad || hmiss) begin
                    set_hlen  = line_bad | hmiss;
                    set_vlen  = frame_bad;
                    state_nxt = SEEK;
                end else if (vfall) begin
                    report = 1'b1;
                end
            end
            default: state_nxt = SEEK;
        endcase
    end

    // Stage p0: raw pixel capture (data only, no reset needed)
    always_ff @(posedge clk) begin
        rgb_p0 <= rgb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_p0       <= 1'b1;
            hs_p1       <= 1'b1;
            vs_p0       <= 1'b1;
            vs_p1       <= 1'b1;
            hpos        <= '0;
            vpos        <= '0;
            vpend       <= 1'b0;
            state       <= SEEK;
            good_frames <= '0;
            err_hlen    <= 1'b0;
            err_vlen    <= 1'b0;
            acc         <= '0;
            frame_sum   <= '0;
            frame_done  <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
        end else begin
            // Stage p0/p1: sync capture and edge history
            hs_p0 <= hsync;
            hs_p1 <= hs_p0;
            vs_p0 <= vsync;
            vs_p1 <= vs_p0;

            hpos <= hpos_nxt;
            vpos <= vpos_nxt;
            if (hfall)      vpend <= 1'b0;
            else if (vfall) vpend <= 1'b1;

            state       <= state_nxt;
            good_frames <= good_nxt;
            if (set_hlen) err_hlen <= 1'b1;
            if (set_vlen) err_vlen <= 1'b1;

            acc        <= vfall ? 24'd0 : acc_sum;
            frame_done <= report;
            if (report) frame_sum <= acc_sum;

            // Stage p1: pixel output
            pix_valid <= (state == LOCKED) && active_nxt;
            if ((state == LOCKED) && active_nxt) begin
                pix_x   <= 10'(hpos_nxt - H_FIRST);
                pix_y   <= vpos_nxt - V_FIRST;
                pix_rgb <= rgb_p0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a shrunken 25x13 raster so every
// scenario (lock, checksum, bad line/frame, missing hsync, reset) fits in a few thousand clocks.
module tb_vga_sync_monitor;

    localparam int H_ACTIVE = 16;
    localparam int H_FRONT  = 2;
    localparam int H_SYNC   = 4;
    localparam int H_BACK   = 3;
    localparam int V_ACTIVE = 8;
    localparam int V_FRONT  = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 2;
    localparam int H_TOTAL  = 25;
    localparam int V_TOTAL  = 13;
    localparam int HS       = H_SYNC + H_BACK;
    localparam int VS       = V_SYNC + V_BACK;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync, vsync;
    logic [11:0] rgb;
    logic        locked, pix_valid, frame_done, err_hlen, err_vlen;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_rgb;
    logic [23:0] frame_sum;

    vga_sync_monitor #(
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .frame_done(frame_done), .frame_sum(frame_sum),
        .err_hlen(err_hlen), .err_vlen(err_vlen)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    logic        mon_en = 1'b0;
    int          ex = 0, ey = 0, run = 0, vcnt = 0;
    logic [11:0] rgb_d1 = '0, rgb_d2 = '0;
    int          fd_cnt = 0, fd_cyc = -1, fd_gap = 0;
    logic [23:0] fd_sum = '0;
    logic        lk_q = 1'b0, eh_q = 1'b0, ev_q = 1'b0;
    int          lk_drop_cyc = 0, eh_cyc = 0, ev_cyc = 0;

    always @(negedge clk) begin
        if (mon_en && pix_valid) begin
            chk("pix_rgb", 32'(pix_rgb), 32'(rgb_d2));
            chk("pix_x", 32'(pix_x), 32'(ex));
            chk("pix_y", 32'(pix_y), 32'(ey));
            run++;
            vcnt++;
            ex++;
            if (ex == H_ACTIVE) begin
                ex = 0;
                ey = (ey + 1) % V_ACTIVE;
            end
        end else if (mon_en && run != 0) begin
            chk("run_len", 32'(run), 32'(H_ACTIVE));
            run = 0;
        end
        rgb_d2 = rgb_d1;
        rgb_d1 = rgb;
        if (frame_done) begin
            if (fd_cyc >= 0) fd_gap = cyc - fd_cyc;
            fd_cyc = cyc;
            fd_cnt++;
            fd_sum = frame_sum;
        end
        if (lk_q && !locked)    lk_drop_cyc = cyc;
        if (!eh_q && err_hlen)  eh_cyc = cyc;
        if (!ev_q && err_vlen)  ev_cyc = cyc;
        lk_q = locked;
        eh_q = err_hlen;
        ev_q = err_vlen;
    end

    int last_hfall_cyc = 0, last_vfall_cyc = 0, mark_cyc = 0;

    task automatic drive(input logic hs, input logic vs, input logic [11:0] c);
        @(posedge clk);
        #1;
        hsync = hs;
        vsync = vs;
        rgb   = c;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_locked"},    32'(locked),     32'd0);
        chk({tag, "_pix_valid"}, 32'(pix_valid),  32'd0);
        chk({tag, "_pix_x"},     32'(pix_x),      32'd0);
        chk({tag, "_pix_y"},     32'(pix_y),      32'd0);
        chk({tag, "_pix_rgb"},   32'(pix_rgb),    32'd0);
        chk({tag, "_frame_done"},32'(frame_done), 32'd0);
        chk({tag, "_frame_sum"}, 32'(frame_sum),  32'd0);
        chk({tag, "_err_hlen"},  32'(err_hlen),   32'd0);
        chk({tag, "_err_vlen"},  32'(err_vlen),   32'd0);
    endtask

    // mode 0: constant 12'hFFF; mode 1: {row[5:0], col[5:0]} inside the active window
    task automatic send_frame(input int nlines, input int short_line, input int mode, input int rst_line);
        int          len, x, y;
        logic        act;
        logic [11:0] c;
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_line) ? H_TOTAL - 1 : H_TOTAL;
            for (int h = 0; h < len; h++) begin
                x   = h - HS;
                y   = l - VS;
                act = (h >= HS) && (h < HS + H_ACTIVE) && (l >= VS) && (l < VS + V_ACTIVE);
                if (mode == 0) c = 12'hFFF;
                else           c = act ? 12'((y << 6) | x) : 12'h000;
                drive((h < H_SYNC) ? 1'b0 : 1'b1, (l < V_SYNC) ? 1'b0 : 1'b1, c);
                if (h == 0) begin
                    last_hfall_cyc = cyc;
                    if (l == 0) last_vfall_cyc = cyc;
                    if (short_line >= 0 && l == short_line + 1) mark_cyc = cyc;
                end
                if (l == rst_line && h == HS + 3) begin
                    rst = 1'b1;
                    #1;
                    check_all_zero("midrst");
                end else if (rst) begin
                    rst = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        rgb   = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Nominal timing, constant white: lock on the third frame start
        send_frame(V_TOTAL, -1, 0, -1);
        send_frame(V_TOTAL, -1, 0, -1);
        chk("lock_after_2_frames", 32'(locked), 32'd0);
        send_frame(V_TOTAL, -1, 0, -1);
        chk("lock_after_3rd_start", 32'(locked), 32'd1);
        send_frame(V_TOTAL, -1, 0, -1);
        send_frame(V_TOTAL, -1, 0, -1);
        chk("fd_count_white", 32'(fd_cnt), 32'd2);
        chk("frame_sum_white", 32'(fd_sum), 32'h07FF80);
        chk("fd_period", 32'(fd_gap), 32'(H_TOTAL * V_TOTAL));
        chk("err_hlen_nominal", 32'(err_hlen), 32'd0);
        chk("err_vlen_nominal", 32'(err_vlen), 32'd0);

        // Gradient: coordinates, pixel pipeline and checksum
        ex = 0; ey = 0; run = 0; vcnt = 0;
        mon_en = 1'b1;
        send_frame(V_TOTAL, -1, 1, -1);
        send_frame(V_TOTAL, -1, 1, -1);
        mon_en = 1'b0;
        chk("valid_count", 32'(vcnt), 32'(2 * H_ACTIVE * V_ACTIVE));
        chk("fd_count_grad", 32'(fd_cnt), 32'd4);
        chk("frame_sum_grad", 32'(fd_sum), 32'h0073C0);

        // Missing hsync while locked
        repeat (2100) drive(1'b1, 1'b1, 12'hFFF);
        chk("hmiss_err_lat", 32'(eh_cyc - last_hfall_cyc), 32'd2050);
        chk("hmiss_unlock_lat", 32'(lk_drop_cyc - last_hfall_cyc), 32'd2050);
        chk("hmiss_locked", 32'(locked), 32'd0);
        chk("hmiss_err_hlen", 32'(err_hlen), 32'd1);
        send_frame(V_TOTAL, -1, 0, -1);
        send_frame(V_TOTAL, -1, 0, -1);
        send_frame(V_TOTAL, -1, 0, -1);
        chk("relock_after_hmiss", 32'(locked), 32'd1);

        // One 24-clock line while locked
        send_frame(V_TOTAL, 5, 0, -1);
        chk("short_unlock_lat", 32'(lk_drop_cyc - mark_cyc), 32'd2);
        chk("short_locked", 32'(locked), 32'd0);
        send_frame(V_TOTAL, -1, 0, -1);
        send_frame(V_TOTAL, -1, 0, -1);
        chk("short_relock_early", 32'(locked), 32'd0);
        send_frame(V_TOTAL, -1, 0, -1);
        chk("short_relock", 32'(locked), 32'd1);
        chk("short_err_hlen_sticky", 32'(err_hlen), 32'd1);
        chk("short_err_vlen", 32'(err_vlen), 32'd0);
        chk("fd_count_short", 32'(fd_cnt), 32'd5);

        // One frame of V_TOTAL-1 lines while locked
        send_frame(V_TOTAL - 1, -1, 0, -1);
        send_frame(V_TOTAL, -1, 0, -1);
        chk("vlen_err_lat", 32'(ev_cyc - last_vfall_cyc), 32'd2);
        chk("vlen_err", 32'(err_vlen), 32'd1);
        chk("vlen_locked", 32'(locked), 32'd0);
        chk("fd_count_vlen", 32'(fd_cnt), 32'd6);
        send_frame(V_TOTAL, -1, 0, -1);
        send_frame(V_TOTAL, -1, 0, -1);
        send_frame(V_TOTAL, -1, 0, -1);
        chk("vlen_relock", 32'(locked), 32'd1);

        // Asynchronous reset in the middle of an active line
        send_frame(V_TOTAL, -1, 0, 6);
        chk("post_rst_locked", 32'(locked), 32'd0);
        send_frame(V_TOTAL, -1, 0, -1);
        send_frame(V_TOTAL, -1, 0, -1);
        chk("post_rst_lock_early", 32'(locked), 32'd0);
        send_frame(V_TOTAL, -1, 0, -1);
        chk("post_rst_lock", 32'(locked), 32'd1);
        chk("post_rst_err_hlen", 32'(err_hlen), 32'd0);
        chk("post_rst_err_vlen", 32'(err_vlen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
